// File: rtl/rs_bram_sync_fifo.sv
// rs_bram_sync_fifo: single-clock FIFO mapped onto one 36Kb TDP block RAM with flags, count and flush
module rs_bram_sync_fifo #(
    parameter int DATA_WIDTH        = 18,
    parameter int ADDR_WIDTH        = 10,
    parameter int PROG_FULL_THRESH  = 1020,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RDATA_VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  PROG_EMPTY,
    output logic                  PROG_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SH    = DATA_WIDTH <= 4 ? $clog2(DATA_WIDTH) : DATA_WIDTH <= 9 ? 3 : DATA_WIDTH <= 18 ? 4 : 5;
    localparam bit PAR   = (DATA_WIDTH % 9) == 0;

    if (!(DATA_WIDTH == 1 || DATA_WIDTH == 2 || DATA_WIDTH == 4 || DATA_WIDTH == 8 || DATA_WIDTH == 9 ||
          DATA_WIDTH == 16 || DATA_WIDTH == 18 || DATA_WIDTH == 32 || DATA_WIDTH == 36)) begin : g_bad_width
        $error("rs_bram_sync_fifo: unsupported DATA_WIDTH %0d", DATA_WIDTH);
    end
    if (DATA_WIDTH * DEPTH > 36864) begin : g_bad_depth
        $error("rs_bram_sync_fifo: DATA_WIDTH * depth exceeds one 36Kb block RAM");
    end
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pf
        $error("rs_bram_sync_fifo: PROG_FULL_THRESH out of range");
    end
    if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH >= DEPTH) begin : g_bad_pe
        $error("rs_bram_sync_fifo: PROG_EMPTY_THRESH out of range");
    end

    // 1024 rows of two 18-bit halves; each half holds 16 data bits plus 2 parity bits
    logic [35:0]           r_mem [1024];
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_valid, r_empty, r_full, r_pe, r_pf, r_ovf, r_unf;
    logic                  w_wr_ok, w_rd_ok;
    logic [ADDR_WIDTH:0]   w_cnt_nxt;
    logic [14:0]           w_waddr, w_raddr;
    logic [DATA_WIDTH-1:0] w_rword;

    // Physical bit within a 36-bit row for logical bit i of a word placed at data-bit offset col.
    // In 9/18/36 modes bit 8 of each 9-bit lane goes to the parity bit of its byte lane.
    function automatic logic [5:0] phys(input logic [4:0] col, input int i);
        int lane, d;
        lane = int'(col) / 8 + i / 9;
        d    = int'(col) + (PAR ? (i / 9) * 8 + i % 9 : i);
        return (PAR && (i % 9) == 8) ? 6'((lane / 2) * 18 + 16 + lane % 2) : 6'((d / 16) * 18 + d % 16);
    endfunction

    assign w_wr_ok   = WR_EN & ~r_full;
    assign w_rd_ok   = RD_EN & ~r_empty;
    assign w_cnt_nxt = r_count + (ADDR_WIDTH+1)'(w_wr_ok) - (ADDR_WIDTH+1)'(w_rd_ok);
    assign w_waddr   = 15'(r_wptr) << SH;
    assign w_raddr   = 15'(r_rptr) << SH;

    // Memory write port; contents survive reset and flush
    always_ff @(posedge CLK) begin
        if (w_wr_ok)
            for (int i = 0; i < DATA_WIDTH; i++)
                r_mem[w_waddr[14:5]][phys(w_waddr[4:0], i)] <= WDATA[i];
    end

    // Gather the word at the read pointer back out of its data/parity lanes
    always_comb begin
        w_rword = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            w_rword[i] = r_mem[w_raddr[14:5]][phys(w_raddr[4:0], i)];
    end

    // Pointers, occupancy, registered flags and read data; flush outranks requests
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdata <= '0;
            r_valid <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_pe    <= 1'b1;
            r_pf    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (FLUSH) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_pe    <= 1'b1;
            r_pf    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + ADDR_WIDTH'(w_wr_ok);
            r_rptr  <= r_rptr + ADDR_WIDTH'(w_rd_ok);
            r_count <= w_cnt_nxt;
            r_valid <= w_rd_ok;
            r_empty <= w_cnt_nxt == '0;
            r_full  <= w_cnt_nxt == (ADDR_WIDTH+1)'(DEPTH);
            r_pe    <= int'(w_cnt_nxt) <= PROG_EMPTY_THRESH;
            r_pf    <= int'(w_cnt_nxt) >= PROG_FULL_THRESH;
            r_ovf   <= WR_EN & r_full;
            r_unf   <= RD_EN & r_empty;
            if (w_rd_ok)
                r_rdata <= w_rword;
        end
    end

    assign RDATA       = r_rdata;
    assign RDATA_VALID = r_valid;
    assign EMPTY       = r_empty;
    assign FULL        = r_full;
    assign PROG_EMPTY  = r_pe;
    assign PROG_FULL   = r_pf;
    assign COUNT       = r_count;
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_unf;
endmodule

// File: tb/tb_rs_bram_sync_fifo.sv
// tb_rs_bram_sync_fifo: scoreboard bench for the block-RAM FIFO in 9-bit and 36-bit modes
module tb_rs_bram_sync_fifo;
    logic        clk = 1'b0;
    logic        rst, flush, wr, rd;
    logic [8:0]  wd, rdata;
    logic        valid, empty, full, pe, pf, ovf, unf;
    logic [4:0]  count;
    logic        flush36, wr36, rd36;
    logic [35:0] wd36, rdata36;
    logic        valid36, empty36, full36, pe36, pf36, ovf36, unf36;
    logic [4:0]  count36;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  m_q[$];
    logic [8:0]  sb[$];
    logic        e_valid, e_ovf, e_unf;

    always #5 clk = ~clk;

    rs_bram_sync_fifo #(.DATA_WIDTH(9), .ADDR_WIDTH(4), .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) dut (
        .CLK(clk), .RESET(rst), .FLUSH(flush), .WR_EN(wr), .WDATA(wd), .RD_EN(rd),
        .RDATA(rdata), .RDATA_VALID(valid), .EMPTY(empty), .FULL(full), .PROG_EMPTY(pe),
        .PROG_FULL(pf), .COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(unf));

    rs_bram_sync_fifo #(.DATA_WIDTH(36), .ADDR_WIDTH(4), .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(2)) u36 (
        .CLK(clk), .RESET(rst), .FLUSH(flush36), .WR_EN(wr36), .WDATA(wd36), .RD_EN(rd36),
        .RDATA(rdata36), .RDATA_VALID(valid36), .EMPTY(empty36), .FULL(full36), .PROG_EMPTY(pe36),
        .PROG_FULL(pf36), .COUNT(count36), .OVERFLOW(ovf36), .UNDERFLOW(unf36));

    // One clock of stimulus; the model decides acceptance from the state before the edge
    task automatic drive(input logic w, input logic [8:0] d, input logic r);
        bit m_full  = m_q.size() == 16;
        bit m_empty = m_q.size() == 0;
        wr = w; wd = d; rd = r;
        e_ovf   = w && m_full;
        e_unf   = r && m_empty;
        e_valid = r && !m_empty;
        if (e_valid) sb.push_back(m_q.pop_front());
        if (w && !m_full) m_q.push_back(d);
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; wd = '0;
        flush36 = 1'b0; wr36 = 1'b0; rd36 = 1'b0; wd36 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdata, valid, empty, full, pe, pf, count, ovf, unf} !== {9'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdata=%h v=%b e=%b f=%b pe=%b pf=%b cnt=%0d ov=%b un=%b want 0/0/1/0/1/0/0/0/0",
                     rdata, valid, empty, full, pe, pf, count, ovf, unf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [8:0] exp;
        drive(1, 9'h1A5, 0);
        drive(1, 9'h05A, 0);
        drive(1, 9'h100, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1);
            exp = sb.pop_front();
            checks++;
            if (valid !== 1'b1 || rdata !== exp) begin
                errors++;
                $display("FAIL basic_read%0d: got v=%b data=%h want v=1 data=%h", i, valid, rdata, exp);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL basic_empty: got empty=%b count=%0d want 1/0", empty, count);
        end
        drive(0, 0, 0);
        checks++;
        if (valid !== 1'b0 || rdata !== 9'h100) begin
            errors++;
            $display("FAIL basic_hold: got v=%b data=%h want v=0 data=100", valid, rdata);
        end
    endtask

    task automatic test_full();
        logic [8:0] exp;
        for (int i = 0; i < 16; i++) drive(1, 9'(i * 7 + 32), 0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL full_flag: got full=%b count=%0d want 1/16", full, count);
        end
        drive(1, 9'h1FF, 0);
        checks++;
        if (ovf !== e_ovf || ovf !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL full_overflow: got ovf=%b count=%0d want 1/16", ovf, count);
        end
        drive(0, 0, 0);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pulse: got ovf=%b want 0", ovf);
        end
        drive(1, 9'h0AA, 1);
        exp = sb.pop_front();
        checks++;
        if (ovf !== 1'b1 || count !== 5'd15 || valid !== 1'b1 || rdata !== exp) begin
            errors++;
            $display("FAIL full_rdwr: got ovf=%b count=%0d v=%b data=%h want 1/15/1/%h", ovf, count, valid, rdata, exp);
        end
        while (m_q.size() != 0) begin
            drive(0, 0, 1);
            exp = sb.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL full_drain: got %h want %h", rdata, exp);
            end
        end
    endtask

    task automatic test_underflow();
        drive(1, 9'h133, 1);
        checks++;
        if (unf !== e_unf || unf !== 1'b1 || count !== 5'd1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_rdwr: got unf=%b count=%0d v=%b want 1/1/0", unf, count, valid);
        end
        drive(0, 0, 1);
        checks++;
        if (valid !== 1'b1 || rdata !== sb.pop_front() || unf !== 1'b0) begin
            errors++;
            $display("FAIL empty_readback: got v=%b data=%h unf=%b want 1/133/0", valid, rdata, unf);
        end
    endtask

    task automatic test_prog();
        logic [3:0] got, want;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) drive(1, 9'($urandom), 0);
            else begin
                drive(0, 0, 1);
                void'(sb.pop_front());
            end
            got  = {pe, pf, empty, full};
            want = {m_q.size() <= 2, m_q.size() >= 12, m_q.size() == 0, m_q.size() == 16};
            checks++;
            if (got !== want || count !== 5'(m_q.size())) begin
                errors++;
                $display("FAIL prog_flags step%0d: got pe/pf/e/f=%b cnt=%0d want %b cnt=%0d", i, got, count, want, m_q.size());
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp;
        for (int i = 0; i < 5; i++) drive(1, 9'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            drive(1, 9'($urandom), 1);
            exp = sb.pop_front();
            checks++;
            if (valid !== 1'b1 || rdata !== exp || count !== 5'd5) begin
                errors++;
                $display("FAIL wrap_pair%0d: got v=%b data=%h cnt=%0d want 1/%h/5", i, valid, rdata, count, exp);
            end
        end
        while (m_q.size() != 0) begin
            drive(0, 0, 1);
            exp = sb.pop_front();
            checks++;
            if (rdata !== exp) begin
                errors++;
                $display("FAIL wrap_drain: got %h want %h", rdata, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [8:0] held;
        for (int i = 0; i < 7; i++) drive(1, 9'(i + 9'h150), 0);
        held = rdata;
        flush = 1'b1; wr = 1'b1; rd = 1'b1; wd = 9'h1EE;
        @(posedge clk); #1;
        flush = 1'b0; wr = 1'b0; rd = 1'b0;
        m_q.delete();
        checks++;
        if ({count, empty, full, pe, pf, ovf, unf, valid} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} || rdata !== held) begin
            errors++;
            $display("FAIL flush_state: got cnt=%0d e=%b f=%b pe=%b pf=%b ov=%b un=%b v=%b data=%h want 0/1/0/1/0/0/0/0 data=%h",
                     count, empty, full, pe, pf, ovf, unf, valid, rdata, held);
        end
        drive(1, 9'h077, 0);
        drive(0, 0, 1);
        checks++;
        if (rdata !== sb.pop_front() || valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got data=%h v=%b want 077/1", rdata, valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 9'h0F1, 0);
        drive(1, 9'h0F2, 0);
        drive(0, 0, 1);
        void'(sb.pop_front());
        wr = 1'b1; wd = 9'h0F3;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rdata, valid, empty, full, pe, pf, count, ovf, unf} !== {9'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got rdata=%h v=%b e=%b f=%b pe=%b pf=%b cnt=%0d ov=%b un=%b want 0/0/1/0/1/0/0/0/0",
                     rdata, valid, empty, full, pe, pf, count, ovf, unf);
        end
        wr = 1'b0;
        #1 rst = 1'b0;
        m_q.delete();
        sb.delete();
        @(posedge clk); #1;
        drive(1, 9'h0C3, 0);
        drive(0, 0, 1);
        checks++;
        if (rdata !== sb.pop_front() || count !== 5'd0) begin
            errors++;
            $display("FAIL reset_restart: got data=%h cnt=%0d want 0c3/0", rdata, count);
        end
    endtask

    task automatic test_w36();
        logic [35:0] q36[$];
        logic [35:0] exp;
        q36.push_back(36'h9_A5A5_5A5A);
        q36.push_back(36'h6_5A5A_A5A5);
        for (int i = 0; i < 2; i++) begin
            wr36 = 1'b1; wd36 = q36[i];
            @(posedge clk); #1;
        end
        wr36 = 1'b0; rd36 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp = q36.pop_front();
            checks++;
            if (valid36 !== 1'b1 || rdata36 !== exp) begin
                errors++;
                $display("FAIL w36_read%0d: got v=%b data=%h want 1/%h", i, valid36, rdata36, exp);
            end
        end
        rd36 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (empty36 !== 1'b1 || count36 !== 5'd0) begin
            errors++;
            $display("FAIL w36_empty: got empty=%b cnt=%0d want 1/0", empty36, count36);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_prog();
        test_wrap();
        test_flush();
        test_async_reset();
        test_w36();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
